// File: rtl/clock_time_counter_pkg.sv
// Shared time-of-day definitions: BCD digit type, per-field wrap limits, display digit indices.
package clock_time_counter_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_MAX_TENS   = 4'd5;
   localparam bcd_t SEC_MAX_UNITS  = 4'd9;
   localparam bcd_t MIN_MAX_TENS   = 4'd5;
   localparam bcd_t MIN_MAX_UNITS  = 4'd9;
   localparam bcd_t HOUR_MAX_TENS  = 4'd2;
   localparam bcd_t HOUR_MAX_UNITS = 4'd3;

   typedef enum logic [2:0] {
      DIG_SEC_UNITS  = 3'd0,
      DIG_SEC_TENS   = 3'd1,
      DIG_MIN_UNITS  = 3'd2,
      DIG_MIN_TENS   = 3'd3,
      DIG_HOUR_UNITS = 3'd4,
      DIG_HOUR_TENS  = 3'd5
   } digit_idx_e;

endpackage

// File: rtl/clock_time_counter_bcd_digit_pair.sv
// Two-digit BCD counter wrapping to 00 after max_tens_i:max_units_i; clear beats increment.
// Digits are registered; wrap_o is combinational and only fires on an increment that wraps.
module bcd_digit_pair
   import clock_time_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  bcd_t max_tens_i,
   input  bcd_t max_units_i,
   input  logic inc_i,
   input  logic clr_i,
   output bcd_t tens_o,
   output bcd_t units_o,
   output logic wrap_o
);

   bcd_t tens_q, tens_d;
   bcd_t units_q, units_d;
   logic at_max;

   assign at_max = (tens_q == max_tens_i) && (units_q == max_units_i);
   assign wrap_o = inc_i && !clr_i && at_max;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (clr_i) begin
         tens_d  = '0;
         units_d = '0;
      end else if (inc_i) begin
         if (at_max) begin
            tens_d  = '0;
            units_d = '0;
         end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 4'd1;
            units_d = '0;
         end else begin
            units_d = units_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q  <= '0;
         units_q <= '0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens_o  = tens_q;
   assign units_o = units_q;

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour hh:mm:ss BCD time-of-day counter with 1 Hz prescaler, minute/hour adjust and seconds clear.
// Digits, tick_1hz and hour_strobe are registered: one cycle after the tick or adjust pulse.
module clock_time_counter
   import clock_time_counter_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic inc_min,
   input  logic inc_hour,
   input  logic clr_sec,
   output bcd_t bcd0,
   output bcd_t bcd1,
   output bcd_t bcd2,
   output bcd_t bcd3,
   output bcd_t bcd4,
   output bcd_t bcd5,
   output logic tick_1hz,
   output logic hour_strobe
);

   localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          strobe_q, strobe_d;
   logic          tick;
   logic          sec_wrap, min_wrap, hour_wrap_unused;
   logic          min_inc, hour_inc, hour_carry;

   assign tick = run && (presc_q == PRESC_LAST);

   always_comb begin
      presc_d = presc_q;
      if (clr_sec)
         presc_d = '0;
      else if (tick)
         presc_d = '0;
      else if (run)
         presc_d = presc_q + PW'(1);
   end

   // Carry into hours only when the minute wrap came from a seconds carry, never from inc_min.
   assign min_inc    = sec_wrap || inc_min;
   assign hour_carry = sec_wrap && min_wrap;
   assign hour_inc   = hour_carry || inc_hour;

   assign tick_d   = tick && !clr_sec;
   assign strobe_d = hour_carry;

   bcd_digit_pair u_sec (
      .clk        (clk),
      .rst_n      (rst_n),
      .max_tens_i (SEC_MAX_TENS),
      .max_units_i(SEC_MAX_UNITS),
      .inc_i      (tick),
      .clr_i      (clr_sec),
      .tens_o     (bcd1),
      .units_o    (bcd0),
      .wrap_o     (sec_wrap)
   );

   bcd_digit_pair u_min (
      .clk        (clk),
      .rst_n      (rst_n),
      .max_tens_i (MIN_MAX_TENS),
      .max_units_i(MIN_MAX_UNITS),
      .inc_i      (min_inc),
      .clr_i      (1'b0),
      .tens_o     (bcd3),
      .units_o    (bcd2),
      .wrap_o     (min_wrap)
   );

   bcd_digit_pair u_hour (
      .clk        (clk),
      .rst_n      (rst_n),
      .max_tens_i (HOUR_MAX_TENS),
      .max_units_i(HOUR_MAX_UNITS),
      .inc_i      (hour_inc),
      .clr_i      (1'b0),
      .tens_o     (bcd5),
      .units_o    (bcd4),
      .wrap_o     (hour_wrap_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         tick_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         strobe_q <= strobe_d;
      end
   end

   assign tick_1hz    = tick_q;
   assign hour_strobe = strobe_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with TICKS_PER_SEC=4; inputs change and outputs are sampled on falling edges.
module tb_clock_time_counter;
   import clock_time_counter_pkg::*;

   logic clk = 1'b0;
   logic rst_n, run, inc_min, inc_hour, clr_sec;
   bcd_t bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;
   logic tick_1hz, hour_strobe;
   logic [23:0] now;

   int n_cmp = 0;
   int n_err = 0;

   clock_time_counter #(.TICKS_PER_SEC(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .inc_min    (inc_min),
      .inc_hour   (inc_hour),
      .clr_sec    (clr_sec),
      .bcd0       (bcd0),
      .bcd1       (bcd1),
      .bcd2       (bcd2),
      .bcd3       (bcd3),
      .bcd4       (bcd4),
      .bcd5       (bcd5),
      .tick_1hz   (tick_1hz),
      .hour_strobe(hour_strobe)
   );

   always #5 clk = ~clk;

   assign now = {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

   function automatic logic [23:0] hms(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds one adjust input high for n cycles (n increments); no hour strobe may appear.
   task automatic hold(input logic is_hour, input int n);
      int strobes = 0;
      if (is_hour) inc_hour = 1'b1;
      else         inc_min  = 1'b1;
      repeat (n) begin
         @(negedge clk);
         strobes += int'(hour_strobe);
      end
      inc_hour = 1'b0;
      inc_min  = 1'b0;
      chk("adjust_no_strobe", 24'(strobes), 24'd0);
   endtask

   // Runs exactly n seconds starting from prescaler phase 0.
   task automatic run_secs(input int n);
      int ticks = 0;
      run = 1'b1;
      repeat (4 * n) begin
         @(negedge clk);
         ticks += int'(tick_1hz);
      end
      run = 1'b0;
      chk("tick_count", 24'(ticks), 24'(n));
   endtask

   task automatic do_tick(input string tag, input logic [23:0] exp_t, input logic exp_strobe);
      run = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk({tag, "_pre_tick"}, 24'(tick_1hz), 24'd0);
      end
      @(negedge clk);
      run = 1'b0;
      chk({tag, "_time"}, now, exp_t);
      chk({tag, "_tick"}, 24'(tick_1hz), 24'd1);
      chk({tag, "_strobe"}, 24'(hour_strobe), 24'(exp_strobe));
      @(negedge clk);
      chk({tag, "_strobe_drop"}, 24'(hour_strobe), 24'd0);
      chk({tag, "_tick_drop"}, 24'(tick_1hz), 24'd0);
   endtask

   initial begin
      int ticks;
      rst_n = 1'b0; run = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_time", now, hms(0, 0, 0));
      chk("reset_tick", 24'(tick_1hz), 24'd0);
      chk("reset_strobe", 24'(hour_strobe), 24'd0);

      rst_n = 1'b1;
      run   = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         chk("tick_rate", 24'(tick_1hz), 24'(k % 4 == 0));
      end
      chk("ten_seconds", now, hms(0, 0, 10));

      run_secs(49);
      chk("to_0_0_59", now, hms(0, 0, 59));
      hold(1'b0, 59);
      chk("to_0_59_59", now, hms(0, 59, 59));
      do_tick("roll_hour", hms(1, 0, 0), 1'b1);

      hold(1'b1, 22);
      hold(1'b0, 59);
      run_secs(59);
      chk("to_23_59_59", now, hms(23, 59, 59));
      do_tick("roll_day", hms(0, 0, 0), 1'b1);

      hold(1'b1, 23);
      chk("to_23_00_00", now, hms(23, 0, 0));
      hold(1'b1, 1);
      chk("inc_hour_wrap", now, hms(0, 0, 0));

      hold(1'b1, 12);
      hold(1'b0, 59);
      run_secs(30);
      chk("to_12_59_30", now, hms(12, 59, 30));
      hold(1'b0, 1);
      chk("inc_min_wrap_no_hour", now, hms(12, 0, 30));

      hold(1'b0, 5);
      run_secs(29);
      chk("to_12_05_59", now, hms(12, 5, 59));
      run = 1'b1;
      repeat (3) @(negedge clk);
      clr_sec = 1'b1;
      @(negedge clk);
      clr_sec = 1'b0;
      chk("clr_on_tick_time", now, hms(12, 5, 0));
      chk("clr_on_tick_strobe", 24'(hour_strobe), 24'd0);
      repeat (3) begin
         @(negedge clk);
         chk("post_clr_no_tick", 24'(tick_1hz), 24'd0);
      end
      @(negedge clk);
      run = 1'b0;
      chk("post_clr_tick", 24'(tick_1hz), 24'd1);
      chk("post_clr_time", now, hms(12, 5, 1));

      run_secs(58);
      run = 1'b1;
      repeat (3) @(negedge clk);
      inc_min = 1'b1;
      @(negedge clk);
      inc_min = 1'b0;
      run     = 1'b0;
      chk("carry_plus_inc_min", now, hms(12, 6, 0));
      clr_sec = 1'b1;
      inc_min = 1'b1;
      @(negedge clk);
      clr_sec = 1'b0;
      inc_min = 1'b0;
      chk("clr_with_inc_min", now, hms(12, 7, 0));

      run = 1'b1;
      repeat (2) @(negedge clk);
      run   = 1'b0;
      ticks = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         ticks += int'(tick_1hz);
         inc_hour = (i == 10);
      end
      chk("frozen_no_tick", 24'(ticks), 24'd0);
      chk("frozen_inc_hour", now, hms(13, 7, 0));
      run = 1'b1;
      @(negedge clk);
      chk("resume_no_tick", 24'(tick_1hz), 24'd0);
      @(negedge clk);
      chk("resume_tick", 24'(tick_1hz), 24'd1);
      chk("resume_time", now, hms(13, 7, 1));

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_time", now, hms(0, 0, 0));
      chk("mid_reset_tick", 24'(tick_1hz), 24'd0);
      chk("mid_reset_strobe", 24'(hour_strobe), 24'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("restart_tick", 24'(tick_1hz), 24'(k == 4));
      end
      chk("restart_time", now, hms(0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
